// File: rtl/btpipe_block_buffer.sv
// btpipe_block_buffer: block-throttled FIFO feeding a 32-bit BT pipe-out endpoint
module btpipe_block_buffer #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  ti_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic                  full,
  input  logic                  ep_read,
  input  logic                  ep_blockstrobe,
  output logic                  ep_ready,
  output logic [31:0]           ep_datain,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic                  overflow,
  output logic                  underrun
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CAP = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] BLK = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);
  typedef enum logic [1:0] {IDLE, READY, XFER} state_t;
  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   xfer_cnt;
  logic                  wr_ok, pop;
  assign full  = fill_count == CAP;
  assign wr_ok = wr_en && !full;
  assign pop   = ep_read && state == XFER;
  // storage array; contents need no reset because the pointers restart
  always_ff @(posedge ti_clk) if (wr_ok) mem[wr_ptr] <= wr_data;
  // pointers, occupancy, registered read data and sticky error flags
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      ep_datain  <= '0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        ep_datain <= mem[rd_ptr];
      end
      fill_count <= (wr_ok && !pop) ? fill_count + 1'b1 :
                    (!wr_ok && pop) ? fill_count - 1'b1 : fill_count;
      if (wr_en && full) overflow <= 1'b1;
      if (ep_read && !pop) underrun <= 1'b1;
    end
  end
  // block handshake: advertise a stored block, then count its words out
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      state    <= IDLE;
      ep_ready <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (fill_count >= BLK) begin
          state    <= READY;
          ep_ready <= 1'b1;
        end
        READY: if (ep_blockstrobe) begin
          state    <= XFER;
          ep_ready <= 1'b0;
          xfer_cnt <= '0;
        end
        XFER: if (pop) begin
          xfer_cnt <= xfer_cnt + 1'b1;
          if (xfer_cnt + 1'b1 == BLK) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          ep_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_btpipe_block_buffer.sv
// tb_btpipe_block_buffer: table, directed and randomized checks against a queue model
module tb_btpipe_block_buffer;
  logic        ti_clk = 1'b0, reset = 1'b1, wr_en = 1'b0, ep_read = 1'b0, ep_blockstrobe = 1'b0;
  logic [31:0] wr_data = '0;
  logic        full, ep_ready, overflow, underrun;
  logic [31:0] ep_datain;
  logic [3:0]  fill_count;
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  int          m_mode, m_left;
  bit          m_rdy, m_ovf, m_und;
  logic [31:0] m_dat;
  typedef struct {bit w; logic [31:0] d; bit r; bit b; int fill; bit rdy; logic [31:0] dat;} vec_t;
  vec_t tbl[11];

  btpipe_block_buffer #(.DEPTH_LOG2(3), .BLOCK_WORDS(4)) dut (
    .ti_clk(ti_clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe), .ep_ready(ep_ready),
    .ep_datain(ep_datain), .fill_count(fill_count), .overflow(overflow), .underrun(underrun));

  always #5 ti_clk = ~ti_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_left = 0; m_rdy = 0; m_ovf = 0; m_und = 0; m_dat = '0;
  endtask

  // words leave in write order; a block is offered once four are stored
  task automatic model_edge(input bit w, input logic [31:0] d, input bit r, input bit b);
    int  sz = q.size();
    bit  f  = sz == 8;
    bit  p  = r && m_mode == 2;
    if (r && !p) m_und = 1;
    if (w && f) m_ovf = 1;
    if (p) m_dat = q.pop_front();
    if (w && !f) q.push_back(d);
    if (m_mode == 0 && sz >= 4) begin m_mode = 1; m_rdy = 1; end
    else if (m_mode == 1 && b) begin m_mode = 2; m_left = 4; m_rdy = 0; end
    else if (m_mode == 2 && p) begin m_left--; if (m_left == 0) m_mode = 0; end
  endtask

  task automatic compare_all();
    chk("fill_count", 32'(fill_count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("ep_ready", 32'(ep_ready), 32'(m_rdy));
    chk("ep_datain", ep_datain, m_dat);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underrun", 32'(underrun), 32'(m_und));
  endtask

  task automatic step(input bit w, input logic [31:0] d, input bit r, input bit b);
    wr_en = w; wr_data = d; ep_read = r; ep_blockstrobe = b;
    @(posedge ti_clk);
    model_edge(w, d, r, b);
    #1;
    compare_all();
    wr_en = 0; ep_read = 0; ep_blockstrobe = 0;
  endtask

  task automatic do_reset();
    wr_en = 0; ep_read = 0; ep_blockstrobe = 0; reset = 1;
    @(posedge ti_clk);
    model_reset();
    #1;
    reset = 0;
    compare_all();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ep_ready && n < 12) begin step(0, 0, 0, 0); n++; end
    chk("ready_timeout", 32'(ep_ready), 32'd1);
  endtask

  task automatic read_block();
    wait_ready();
    step(0, 0, 0, 1);
    repeat (4) step(0, 0, 1, 0);
  endtask

  initial begin
    tbl[0]  = '{1, 32'h11, 0, 0, 1, 0, 32'h0};
    tbl[1]  = '{1, 32'h22, 0, 0, 2, 0, 32'h0};
    tbl[2]  = '{1, 32'h33, 0, 0, 3, 0, 32'h0};
    tbl[3]  = '{1, 32'h44, 0, 0, 4, 0, 32'h0};
    tbl[4]  = '{0, 32'h0,  0, 0, 4, 1, 32'h0};
    tbl[5]  = '{0, 32'h0,  0, 1, 4, 0, 32'h0};
    tbl[6]  = '{0, 32'h0,  1, 0, 3, 0, 32'h11};
    tbl[7]  = '{0, 32'h0,  1, 0, 2, 0, 32'h22};
    tbl[8]  = '{0, 32'h0,  1, 0, 1, 0, 32'h33};
    tbl[9]  = '{0, 32'h0,  1, 0, 0, 0, 32'h44};
    tbl[10] = '{0, 32'h0,  0, 0, 0, 0, 32'h44};
    model_reset();
    repeat (2) @(posedge ti_clk);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].b);
      chk($sformatf("tbl%0d_fill", i), 32'(fill_count), 32'(tbl[i].fill));
      chk($sformatf("tbl%0d_ready", i), 32'(ep_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_data", i), ep_datain, tbl[i].dat);
    end
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(1, 32'h100 + i, 0, 0);
      if (i == 8) chk("full_after_8", 32'(full), 32'd1);
    end
    chk("ovf_after_9", 32'(overflow), 32'd1);
    chk("fill_after_9", 32'(fill_count), 32'd8);
    read_block();
    chk("block1_last", ep_datain, 32'h104);
    chk("gap_ready_low", 32'(ep_ready), 32'd0);
    read_block();
    chk("block2_last", ep_datain, 32'h108);
    for (int i = 0; i < 4; i++) step(1, 32'h200 + i, 0, 0);
    wait_ready();
    step(1, 32'h204, 0, 1);
    for (int i = 5; i <= 8; i++) begin
      step(1, 32'h200 + i, 1, 0);
      chk("overlap_fill", 32'(fill_count), 32'd5);
    end
    chk("wrap_data", ep_datain, 32'h203);
    read_block();
    chk("wrap_block2_last", ep_datain, 32'h207);
    step(1, 32'h209, 0, 0);
    step(0, 0, 1, 0);
    chk("idle_read_underrun", 32'(underrun), 32'd1);
    chk("idle_read_fill", 32'(fill_count), 32'd2);
    chk("idle_read_data", ep_datain, 32'h207);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h300 + i, 0, 0);
    wait_ready();
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    do_reset();
    chk("rst_ready", 32'(ep_ready), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_und", 32'(underrun), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 32'h400 + i, 0, 0);
    read_block();
    chk("post_rst_last", ep_datain, 32'h403);
    chk("post_rst_und", 32'(underrun), 32'd0);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit w = $urandom_range(0, 9) < 6;
      bit b = m_mode == 1 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) == 0;
      bit r = m_mode == 2 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 40) == 0;
      step(w, $urandom, r, b);
      if (i % 500 == 499) do_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
